// File: rtl/sys_defs_pkg.sv
// Shared execute-stage definitions: tag/data widths, the multiplier latency and
// the completion-buffer entry type. `MULT_STAGES defaults to 4 unless the build sets it.
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

package sys_defs;

    localparam int PHYS_REG_IDX_W = 6;
    localparam int DATA_W         = 32;
    localparam int MULT_STAGES    = `MULT_STAGES;

    typedef struct packed {
        logic [PHYS_REG_IDX_W-1:0] tag;
        logic [DATA_W-1:0]         data;
    } MULT_CDB_ENTRY;

endpackage

// File: rtl/mult_cdb_fifo.sv
// Generic DEPTH-entry circular FIFO of W-bit completion entries with an
// occupancy counter that distinguishes full from empty.
module mult_cdb_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(MULT_CDB_ENTRY)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_rdata = r_mem[r_head];

    // NOTE: storage is not reset; r_count alone says which slots hold valid data.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_tail] <= i_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mult_cdb_buffer.sv
// Multiplier completion stage: tag pipe, result FIFO, credit counter and CDB request.
// Define MULT_CDB_BYPASS_EN to broadcast a result in its mult_done cycle when the FIFO is empty.
module mult_cdb_buffer
    import sys_defs::*;
#(
    parameter int STAGES = `MULT_STAGES,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = PHYS_REG_IDX_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              issue_ready,
    input  logic              mult_done,
    input  logic [DATA_W-1:0] mult_result,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CNT_W-1:0]            r_credits;
    logic [STAGES-1:0]           r_pipe_valid;
    logic [STAGES-1:0][TAG_W-1:0] r_pipe_tag;
    logic                        r_err;

    entry_t w_push_entry;
    entry_t w_head;
    logic   w_issue_acc, w_retire, w_bypass;
    logic   w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty;
    logic   w_push_drop;

    assign issue_ready = (r_credits < CNT_W'(DEPTH));
    assign w_issue_acc = issue_valid & issue_ready;
    assign err         = r_err;

`ifdef MULT_CDB_BYPASS_EN
    assign w_bypass = w_fifo_empty & mult_done;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_retire     = cdb_req & cdb_grant;
    assign w_fifo_pop   = w_retire & ~w_bypass;
    assign w_fifo_push  = mult_done & ~(w_bypass & cdb_grant);
    assign w_push_drop  = w_fifo_push & w_fifo_full & ~w_fifo_pop;
    assign w_push_entry = '{tag: r_pipe_tag[STAGES-1], data: mult_result};

    mult_cdb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_fifo_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every output is given a default before any branch, so no path infers a latch.
    always_comb begin
        cdb_req  = 1'b0;
        cdb_tag  = '0;
        cdb_data = '0;
        if (w_bypass) begin
            cdb_req  = 1'b1;
            cdb_tag  = r_pipe_tag[STAGES-1];
            cdb_data = mult_result;
        end else if (!w_fifo_empty) begin
            cdb_req  = 1'b1;
            cdb_tag  = w_head.tag;
            cdb_data = w_head.data;
        end
    end

    // NOTE: state registers use non-blocking assignments so the shift reads pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_valid <= '0;
            r_pipe_tag   <= '0;
        end else begin
            r_pipe_valid[0] <= w_issue_acc;
            r_pipe_tag[0]   <= issue_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_tag[i]   <= r_pipe_tag[i-1];
            end
        end
    end

    // Credits saturate at zero so a stale post-reset result cannot wrap the counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_credits <= '0;
        end else begin
            case ({w_issue_acc, w_retire})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   if (r_credits != '0) r_credits <= r_credits - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((issue_valid & ~issue_ready) |
                     (mult_done ^ r_pipe_valid[STAGES-1]) |
                     w_push_drop) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Scoreboard bench for mult_cdb_buffer: the bench models the multiplier, queues the
// expected {tag, data} at issue time and a negedge monitor compares every granted broadcast.
module tb_mult_cdb_buffer;
    import sys_defs::*;

    localparam int STAGES = 4;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
`ifdef MULT_CDB_BYPASS_EN
    localparam int LAT = STAGES;
`else
    localparam int LAT = STAGES + 1;
`endif

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             issue_valid = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic             issue_ready;
    logic             mult_done = 1'b0;
    logic [31:0]      mult_result = '0;
    logic             cdb_req;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             cdb_grant = 1'b0;
    logic             err;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          tb_credits = 0;
    logic        hv [STAGES];
    logic [31:0] hd [STAGES];
    logic        cur_start = 1'b0;
    logic [31:0] cur_data = '0;
    logic        inj = 1'b0;
    logic [31:0] inj_data = '0;

    mult_cdb_buffer #(.STAGES(STAGES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .mult_done   (mult_done),
        .mult_result (mult_result),
        .cdb_req     (cdb_req),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_grant   (cdb_grant),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every granted broadcast must match the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && cdb_req && cdb_grant) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cdb_unexpected: got tag 0x%0h data 0x%0h expected no broadcast", cdb_tag, cdb_data);
            end else begin
                e = sb.pop_front();
                check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                check("cdb_data", 64'(cdb_data), 64'(e.data));
            end
        end
    end

    // Advance one cycle; the multiplier model delivers done STAGES cycles after start.
    task automatic tick();
        tb_credits += int'(issue_valid && issue_ready) - int'(cdb_req && cdb_grant);
        @(posedge clock);
        #1;
        for (int i = STAGES - 1; i > 0; i--) begin
            hv[i] = hv[i-1];
            hd[i] = hd[i-1];
        end
        hv[0] = cur_start;
        hd[0] = cur_data;
        mult_done   = hv[STAGES-1] | inj;
        mult_result = inj ? inj_data : hd[STAGES-1];
        inj         = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        cur_start   = 1'b0;
        cur_data    = '0;
        #1;
    endtask

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        issue_valid = 1'b1;
        issue_tag   = tag;
        cur_start   = 1'b1;
        cur_data    = data;
        sb.push_back('{tag: tag, data: data});
    endtask

    task automatic clear_model();
        for (int i = 0; i < STAGES; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        cdb_grant = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (sb.size() == 0 && !cdb_req) done = 1;
            else tick();
        end
        check(name, 64'(done), 64'd1);
        cdb_grant = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        clear_model();
        #1 reset_n = 1'b0;
        tick();
        tick();
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_cdb_req", 64'(cdb_req), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_data", 64'(cdb_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single op: tag 0x05, result 0x20, broadcast after LAT cycles.
        check("single_ready_c0", 64'(issue_ready), 64'd1);
        issue(6'h05, 32'h0000_0020);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check("single_ready", 64'(issue_ready), 64'd1);
            check("single_req", 64'(cdb_req), 64'(c == LAT));
        end
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        check("single_req_after", 64'(cdb_req), 64'd0);
        tick();
        check("single_credit_back", 64'(issue_ready), 64'd1);

        // Fill: four issues with no grants exhaust the credits from cycle 4.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", 64'(issue_ready), 64'd1);
            issue(6'(i + 1), 32'h0000_1000 + 32'(i));
            tick();
        end
        check("fill_ready_low", 64'(issue_ready), 64'd0);
        repeat (STAGES) tick();
        check("fill_full_ready", 64'(issue_ready), 64'd0);
        check("fill_head_tag", 64'(cdb_tag), 64'd1);
        check("fill_no_err", 64'(err), 64'd0);

        // Illegal issue while out of credits: flagged, ignored, no credit taken.
        issue_valid = 1'b1;
        issue_tag   = 6'h3F;
        tick();
        check("bad_issue_err", 64'(err), 64'd1);
        check("bad_issue_ready", 64'(issue_ready), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            cdb_grant = 1'b1;
            tick();
            cdb_grant = 1'b0;
            check("fill_credit_back", 64'(issue_ready), 64'd1);
            tick();
        end
        check("fill_drained", 64'(cdb_req), 64'd0);

        // Reset with three entries buffered clears everything at once.
        for (int i = 0; i < 3; i++) begin
            issue(6'(i + 8), 32'h0000_2000 + 32'(i));
            tick();
        end
        repeat (LAT) tick();
        check("pre_rst_req", 64'(cdb_req), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(cdb_req), 64'd0);
        check("mid_rst_ready", 64'(issue_ready), 64'd1);
        check("mid_rst_err", 64'(err), 64'd0);
        sb.delete();
        clear_model();
        tick();
        reset_n = 1'b1;
        tick();

        // Streaming with grant held: issue_ready follows the credit rule, credits stay within DEPTH.
        tb_credits = 0;
        issued = 0;
        cdb_grant = 1'b1;
        for (int c = 0; c < 60 && issued < 8; c++) begin
            check("stream_ready", 64'(issue_ready), 64'(tb_credits < DEPTH));
            if (tb_credits > DEPTH) check("stream_credit_bound", 64'(tb_credits), 64'(DEPTH));
            if (issue_ready) begin
                issue(6'(8'h20 + issued), 32'hA000_0000 + 32'(issued));
                issued++;
            end
            tick();
        end
        check("stream_issued", 64'(issued), 64'd8);
        drain("stream_drain");

        // Wrap: ten ops through the four-entry FIFO under pseudo-random grants.
        issued = 0;
        for (int c = 0; c < 300 && issued < 10; c++) begin
            cdb_grant = 1'($urandom_range(0, 1));
            if (issue_ready) begin
                issue(6'(8'h10 + issued), 32'h0BAD_0000 + 32'(issued * 3));
                issued++;
            end
            tick();
        end
        check("wrap_issued", 64'(issued), 64'd10);
        drain("wrap_drain");
        check("wrap_empty_req", 64'(cdb_req), 64'd0);
        check("wrap_ready", 64'(issue_ready), 64'd1);
        check("traffic_no_err", 64'(err), 64'd0);

        // Stray mult_done with nothing in flight: flagged and pushed with tag 0.
        inj      = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        sb.push_back('{tag: '0, data: 32'hDEAD_BEEF});
        tick();
        tick();
        check("stray_done_err", 64'(err), 64'd1);
        drain("stray_drain");
        check("stray_ready", 64'(issue_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
